// File: rtl/timer.sv
// rtl/timer.sv - programmable one-shot cycle timer with single-cycle end pulse
module timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] curr_time_q,
  output logic             curr_end_q
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] time_d;
  logic             end_d;
  logic [WIDTH-1:0] time_inc;

  assign time_inc = curr_time_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      limit_q     <= '0;
      curr_time_q <= '0;
      curr_end_q  <= 1'b0;
    end else begin
      state       <= state_d;
      limit_q     <= limit_d;
      curr_time_q <= time_d;
      curr_end_q  <= end_d;
    end
  end

  always_comb begin
    state_d = state;
    limit_d = limit_q;
    time_d  = curr_time_q;
    end_d   = 1'b0;
    case (state)
      IDLE: begin
        time_d = '0;
        if (start_i) begin
          // A zero limit completes immediately: pulse end without entering RUN.
          if (n_i == '0) begin
            end_d = 1'b1;
          end else begin
            limit_d = n_i;
            state_d = RUN;
            time_d  = WIDTH'(1);
            end_d   = (n_i == WIDTH'(1));
          end
        end
      end
      RUN: begin
        if (curr_end_q) begin
          state_d = IDLE;
          time_d  = '0;
        end else begin
          time_d = time_inc;
          end_d  = (time_inc == limit_q);
        end
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - randomized self-checking bench for timer against a schedule-queue model
module tb_timer;

  logic        clk;
  logic        rst;
  logic [15:0] n_i;
  logic        start_i;
  logic [15:0] curr_time_q;
  logic        curr_end_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] t;
    logic        e;
  } exp_t;

  // Outputs still owed by the run in progress; empty means the timer is idle.
  exp_t sched[$];

  timer #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .n_i         (n_i),
    .start_i     (start_i),
    .curr_time_q (curr_time_q),
    .curr_end_q  (curr_end_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [15:0] n);
    exp_t x;
    rst     = r;
    start_i = s;
    n_i     = n;
    x.t = '0;
    x.e = 1'b0;
    if (r) begin
      sched.delete();
    end else if (sched.size() != 0) begin
      x = sched.pop_front();
    end else if (s) begin
      if (n == 16'd0) begin
        x.e = 1'b1;
      end else begin
        for (int k = 1; k <= int'(n); k++) begin
          exp_t y;
          y.t = 16'(k);
          y.e = (k == int'(n));
          sched.push_back(y);
        end
        begin
          exp_t z;
          z.t = '0;
          z.e = 1'b0;
          sched.push_back(z);
        end
        x = sched.pop_front();
      end
    end
    @(posedge clk);
    #1;
    check("curr_time_q", 32'(curr_time_q), 32'(x.t));
    check("curr_end_q", 32'(curr_end_q), 32'(x.e));
  endtask

  task automatic idle(input int cycles, input logic [15:0] n);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, n);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    n_i = '0;

    step(1'b1, 1'b0, 16'd0);
    step(1'b1, 1'b1, 16'd7);

    step(1'b0, 1'b1, 16'd10);
    idle(14, 16'd10);

    step(1'b0, 1'b1, 16'd5);
    idle(2, 16'd5);
    idle(6, 16'd10);

    step(1'b0, 1'b1, 16'd10);
    idle(3, 16'd10);
    step(1'b1, 1'b0, 16'd10);
    idle(12, 16'd10);

    step(1'b0, 1'b1, 16'd10);
    step(1'b0, 1'b0, 16'd10);
    step(1'b0, 1'b1, 16'd10);
    step(1'b0, 1'b1, 16'd10);
    idle(10, 16'd10);

    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'd3);
    idle(2, 16'd3);

    step(1'b0, 1'b1, 16'd1);
    idle(3, 16'd1);
    step(1'b0, 1'b1, 16'd0);
    idle(3, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd0);
    idle(2, 16'd0);

    step(1'b1, 1'b1, 16'd4);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'd4);
    idle(3, 16'd4);

    step(1'b0, 1'b1, 16'hFFFF);
    idle(65538, 16'd2);

    for (int i = 0; i < 4000; i++) begin
      logic        r;
      logic        s;
      logic [15:0] n;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 3) == 0);
      n = 16'($urandom_range(0, 14));
      step(r, s, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
